// File: rtl/int_controller_pkg.sv
// Shared constants for the interrupt controller: FSM encoding, default vector
// layout and the handler-address computation.
package int_controller_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam int unsigned VEC_STRIDE_DEF = 4;

  // Handler address wraps modulo 2^32.
  function automatic logic [31:0] calc_vector(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic [31:0] id);
    return base + id * stride;
  endfunction

endpackage

// File: rtl/int_controller_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module int_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Prioritised, maskable interrupt controller sequencing request, acknowledge
// and RETI towards the control unit.
//
// state   | meaning
// IDLE    | no request outstanding; choose a winner from the eligible set
// REQ     | int_req held with frozen int_id/int_vector until int_ack
// SERVICE | handler running; wait for reti
module int_controller
  import int_controller_pkg::*;
#(
  parameter int          N_SRC      = 8,
  parameter int          ID_W       = 3,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask_q,
  output logic [N_SRC-1:0] pending_q,
  output logic             int_req,
  input  logic             int_ack,
  input  logic             reti,
  output logic [ID_W-1:0]  int_id,
  output logic [31:0]      int_vector,
  output logic             in_service
);

  logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] mask_d;
  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;
  logic [31:0]      int_vector_q, int_vector_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic             enc_valid;
  logic [ID_W-1:0]  enc_id;

  assign rise     = irq & ~irq_prev_q;
  assign eligible = pending_q & ~mask_q;

  int_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_comb begin
    irq_prev_d   = irq;
    mask_d       = mask_we ? mask_wdata : mask_q;
    pending_d    = pending_q;
    state_d      = state_q;
    int_id_d     = int_id_q;
    int_vector_d = int_vector_q;

    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          int_id_d     = enc_id;
          int_vector_d = calc_vector(VEC_BASE, 32'(VEC_STRIDE), 32'(enc_id));
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          pending_d[int_id_q] = 1'b0;
          state_d             = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (reti) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge applied last so it survives a same-cycle acknowledge.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      state_q      <= ST_IDLE;
      int_id_q     <= '0;
      int_vector_q <= VEC_BASE;
    end else begin
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      state_q      <= state_d;
      int_id_q     <= int_id_d;
      int_vector_q <= int_vector_d;
    end
  end

  assign int_req    = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign int_id     = int_id_q;
  assign int_vector = int_vector_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed testbench for int_controller with hand-computed expectations.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic [7:0]  mask_q;
  logic [7:0]  pending_q;
  logic        int_req;
  logic        int_ack;
  logic        reti;
  logic [2:0]  int_id;
  logic [31:0] int_vector;
  logic        in_service;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_controller dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .pending_q  (pending_q),
    .int_req    (int_req),
    .int_ack    (int_ack),
    .reti       (reti),
    .int_id     (int_id),
    .int_vector (int_vector),
    .in_service (in_service)
  );

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); rst = 1'b1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_wdata = m; tick(); mask_we = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq = v; tick(); irq = 8'h00;
  endtask

  task automatic ack_and_reti();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; irq = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
    int_ack = 1'b0; reti = 1'b0;
    tick(); tick();
    rst = 1'b1;
    checks++; if (mask_q !== 8'hFF) begin errors++; $display("FAIL reset_mask got=%h exp=ff", mask_q); end
    checks++; if (pending_q !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", pending_q); end
    checks++; if ({int_req, in_service} !== 2'b00) begin errors++; $display("FAIL reset_req_svc got=%b exp=00", {int_req, in_service}); end
    checks++; if (int_id !== 3'd0 || int_vector !== 32'h100) begin errors++; $display("FAIL reset_id_vec got=%0d/%h exp=0/00000100", int_id, int_vector); end
  endtask

  task automatic test_single();
    write_mask(8'h00);
    pulse_irq(8'h08);
    checks++; if (pending_q !== 8'h08 || int_req !== 1'b0) begin errors++; $display("FAIL single_pending got=%h/%b exp=08/0", pending_q, int_req); end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL single_req got=%b exp=1", int_req); end
    checks++; if (int_id !== 3'd3 || int_vector !== 32'h10C) begin errors++; $display("FAIL single_id_vec got=%0d/%h exp=3/0000010c", int_id, int_vector); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++; if (pending_q !== 8'h00 || in_service !== 1'b1 || int_req !== 1'b0) begin errors++; $display("FAIL single_ack got=%h/%b/%b exp=00/1/0", pending_q, in_service, int_req); end
    reti = 1'b1; tick(); reti = 1'b0;
    checks++; if (in_service !== 1'b0 || int_req !== 1'b0) begin errors++; $display("FAIL single_reti got=%b/%b exp=0/0", in_service, int_req); end
    tick();
    checks++; if (int_req !== 1'b0 || int_id !== 3'd3) begin errors++; $display("FAIL single_idle_hold got=%b/%0d exp=0/3", int_req, int_id); end
  endtask

  task automatic test_priority();
    pulse_irq(8'h24);
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 3'd2 || int_vector !== 32'h108) begin errors++; $display("FAIL prio_first got=%b/%0d/%h exp=1/2/00000108", int_req, int_id, int_vector); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++; if (pending_q !== 8'h20) begin errors++; $display("FAIL prio_pending got=%h exp=20", pending_q); end
    reti = 1'b1; tick(); reti = 1'b0;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL prio_reti_idle got=%b exp=0", int_req); end
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 3'd5 || int_vector !== 32'h114) begin errors++; $display("FAIL prio_second got=%b/%0d/%h exp=1/5/00000114", int_req, int_id, int_vector); end
    ack_and_reti();
  endtask

  task automatic test_unmask();
    do_reset();
    pulse_irq(8'h01);
    checks++; if (pending_q !== 8'h01 || int_req !== 1'b0) begin errors++; $display("FAIL unmask_masked got=%h/%b exp=01/0", pending_q, int_req); end
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL unmask_still_masked got=%b exp=0", int_req); end
    write_mask(8'hFE);
    checks++; if (mask_q !== 8'hFE || int_req !== 1'b0) begin errors++; $display("FAIL unmask_write got=%h/%b exp=fe/0", mask_q, int_req); end
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 3'd0 || int_vector !== 32'h100) begin errors++; $display("FAIL unmask_req got=%b/%0d/%h exp=1/0/00000100", int_req, int_id, int_vector); end
    ack_and_reti();
  endtask

  task automatic test_no_withdraw();
    write_mask(8'h00);
    pulse_irq(8'h10);
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 3'd4) begin errors++; $display("FAIL frozen_req got=%b/%0d exp=1/4", int_req, int_id); end
    pulse_irq(8'h02);
    checks++; if (int_id !== 3'd4 || int_vector !== 32'h110 || pending_q !== 8'h12) begin errors++; $display("FAIL frozen_id got=%0d/%h/%h exp=4/00000110/12", int_id, int_vector, pending_q); end
    write_mask(8'h10);
    checks++; if (int_req !== 1'b1 || int_id !== 3'd4) begin errors++; $display("FAIL frozen_masked got=%b/%0d exp=1/4", int_req, int_id); end
    write_mask(8'h00);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++; if (pending_q !== 8'h02) begin errors++; $display("FAIL frozen_ack_pending got=%h exp=02", pending_q); end
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 3'd1 || int_vector !== 32'h104) begin errors++; $display("FAIL frozen_next got=%b/%0d/%h exp=1/1/00000104", int_req, int_id, int_vector); end
    ack_and_reti();
  endtask

  task automatic test_set_wins();
    pulse_irq(8'h40);
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 3'd6 || int_vector !== 32'h118) begin errors++; $display("FAIL setwin_req got=%b/%0d/%h exp=1/6/00000118", int_req, int_id, int_vector); end
    irq = 8'h40; int_ack = 1'b1; tick(); irq = 8'h00; int_ack = 1'b0;
    checks++; if (pending_q !== 8'h40 || in_service !== 1'b1) begin errors++; $display("FAIL setwin_pending got=%h/%b exp=40/1", pending_q, in_service); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++; if (in_service !== 1'b1 || pending_q !== 8'h40) begin errors++; $display("FAIL setwin_stray_ack got=%b/%h exp=1/40", in_service, pending_q); end
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 3'd6) begin errors++; $display("FAIL setwin_rereq got=%b/%0d exp=1/6", int_req, int_id); end
    ack_and_reti();
  endtask

  task automatic test_reset_in_service();
    pulse_irq(8'h08);
    tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL rst_svc_enter got=%b exp=1", in_service); end
    irq = 8'h80; tick();
    do_reset();
    irq = 8'h00;
    checks++; if (in_service !== 1'b0 || int_req !== 1'b0 || mask_q !== 8'hFF || pending_q !== 8'h00) begin errors++; $display("FAIL rst_svc_state got=%b/%b/%h/%h exp=0/0/ff/00", in_service, int_req, mask_q, pending_q); end
    checks++; if (int_id !== 3'd0 || int_vector !== 32'h100) begin errors++; $display("FAIL rst_svc_idvec got=%0d/%h exp=0/00000100", int_id, int_vector); end
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    checks++; if (in_service !== 1'b0 || int_req !== 1'b0 || pending_q !== 8'h00) begin errors++; $display("FAIL rst_svc_stray_reti got=%b/%b/%h exp=0/0/00", in_service, int_req, pending_q); end
  endtask

  task automatic test_mask_and_rise();
    mask_we = 1'b1; mask_wdata = 8'h00; irq = 8'h80;
    tick();
    mask_we = 1'b0; irq = 8'h00;
    checks++; if (pending_q !== 8'h80 || mask_q !== 8'h00) begin errors++; $display("FAIL maskrise_pending got=%h/%h exp=80/00", pending_q, mask_q); end
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 3'd7 || int_vector !== 32'h11C) begin errors++; $display("FAIL maskrise_req got=%b/%0d/%h exp=1/7/0000011c", int_req, int_id, int_vector); end
    ack_and_reti();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_unmask();
    test_no_withdraw();
    test_set_wins();
    test_reset_in_service();
    test_mask_and_rise();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
